// File: rtl/instruction_fetch.sv
// Fetch/decode front end: reads the 24-bit program ROM, resolves flow control
// (JMP, CALL, RET, BREQ) locally and issues the rest over valid/ready.
package def;
    localparam logic [7:0] NOP  = 8'h00;
    localparam logic [7:0] LDI  = 8'h01;
    localparam logic [7:0] CPI  = 8'h02;
    localparam logic [7:0] ADD  = 8'h03;
    localparam logic [7:0] JMP  = 8'h0C;
    localparam logic [7:0] CALL = 8'h0D;
    localparam logic [7:0] RET  = 8'h0E;
    localparam logic [7:0] BREQ = 8'h0F;
endpackage

module instruction_fetch
    import def::*;
#(
    parameter int         STACK_DEPTH = 8,
    parameter logic [7:0] ROM_MAX     = 8'h1A,
    parameter logic [7:0] PC_RESET    = 8'h00
) (
    input  logic        clock,
    input  logic        reset_s2_n,
    output logic [7:0]  rom_address,
    input  logic [23:0] rom_data,
    input  logic        zero_flag,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [7:0]  op_code,
    output logic [7:0]  op1,
    output logic [7:0]  op2,
    output logic [7:0]  pc,
    output logic        fault,
    output logic [1:0]  fault_code
);

    localparam int SPW   = $clog2(STACK_DEPTH + 1);
    localparam int IW    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SLOTS = 1 << IW;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    localparam logic [1:0] F_OVER  = 2'b01;
    localparam logic [1:0] F_UNDER = 2'b10;
    localparam logic [1:0] F_RANGE = 2'b11;

    typedef enum logic [1:0] {
        FETCH,
        DECODE,
        ISSUE,
        HALT
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [7:0]     pc_d;
    logic [7:0]     pc_inc;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_d;
    logic [7:0]     stack [SLOTS];
    logic [7:0]     top;
    logic           push;
    logic           ir_load;
    logic           fault_d;
    logic [1:0]     code_d;
    logic [7:0]     dec_op;
    logic [7:0]     dec_op1;

    assign pc_inc      = pc + 8'd1;
    assign dec_op      = rom_data[23:16];
    assign dec_op1     = rom_data[15:8];
    assign top         = stack[IW'(sp - 1'b1)];
    assign rom_address = pc;
    assign instr_valid = (state == ISSUE);

    always_comb begin
        state_d = state;
        pc_d    = pc;
        sp_d    = sp;
        push    = 1'b0;
        ir_load = 1'b0;
        fault_d = fault;
        code_d  = fault_code;
        unique case (state)
            FETCH: begin
                if (pc > ROM_MAX) begin
                    fault_d = 1'b1;
                    code_d  = F_RANGE;
                    state_d = HALT;
                end else begin
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ir_load = 1'b1;
                state_d = FETCH;
                case (dec_op)
                    JMP: pc_d = dec_op1;
                    CALL: begin
                        if (sp == SP_FULL) begin
                            fault_d = 1'b1;
                            code_d  = F_OVER;
                            state_d = HALT;
                        end else begin
                            push = 1'b1;
                            sp_d = sp + 1'b1;
                            pc_d = dec_op1;
                        end
                    end
                    RET: begin
                        if (sp == '0) begin
                            fault_d = 1'b1;
                            code_d  = F_UNDER;
                            state_d = HALT;
                        end else begin
                            sp_d = sp - 1'b1;
                            pc_d = top;
                        end
                    end
                    BREQ: pc_d = zero_flag ? dec_op1 : pc_inc;
                    default: state_d = ISSUE;
                endcase
            end
            ISSUE: begin
                if (instr_ready) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
            HALT: begin
                state_d = HALT;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            state      <= FETCH;
            pc         <= PC_RESET;
            sp         <= '0;
            fault      <= 1'b0;
            fault_code <= 2'b00;
        end else begin
            state      <= state_d;
            pc         <= pc_d;
            sp         <= sp_d;
            fault      <= fault_d;
            fault_code <= code_d;
        end
    end

    // Instruction register: holds the decoded word stable through ISSUE.
    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            op_code <= 8'h00;
            op1     <= 8'h00;
            op2     <= 8'h00;
        end else if (ir_load) begin
            op_code <= rom_data[23:16];
            op1     <= rom_data[15:8];
            op2     <= rom_data[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            for (int i = 0; i < SLOTS; i++) begin
                stack[i] <= 8'h00;
            end
        end else if (push) begin
            stack[IW'(sp)] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed table, hand sequences and random
// programs checked against an instruction-level model.
`timescale 1ns/1ps
module tb_instruction_fetch;
    import def::*;

    localparam int DEPTH = 8;
    localparam int CAP   = 1000;

    logic        clock = 1'b0;
    logic        reset_s2_n = 1'b0;
    logic [7:0]  rom_address;
    logic [23:0] rom_data;
    logic        zero_flag = 1'b0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [7:0]  op_code;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [7:0]  pc;
    logic        fault;
    logic [1:0]  fault_code;

    logic [23:0] mem [256];
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [23:0] word;
        logic        zf;
        logic [7:0]  pc;
        logic        valid;
        logic        flt;
        logic [1:0]  code;
    } vec_t;

    vec_t tbl [7];

    instruction_fetch #(
        .STACK_DEPTH(DEPTH),
        .ROM_MAX(8'h1A),
        .PC_RESET(8'h00)
    ) dut (
        .clock(clock),
        .reset_s2_n(reset_s2_n),
        .rom_address(rom_address),
        .rom_data(rom_data),
        .zero_flag(zero_flag),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .op_code(op_code),
        .op1(op1),
        .op2(op2),
        .pc(pc),
        .fault(fault),
        .fault_code(fault_code)
    );

    always #10 clock = ~clock;

    always_ff @(posedge clock) rom_data <= mem[rom_address];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = {NOP, 8'h00, 8'h00};
    endtask

    task automatic do_reset();
        reset_s2_n  = 1'b0;
        instr_ready = 1'b0;
        zero_flag   = 1'b0;
        repeat (2) @(negedge clock);
        reset_s2_n = 1'b1;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic rand_trial(input int t);
        logic [31:0] exp_q [$];
        logic [7:0]  stk [$];
        logic [7:0]  ops [7] = '{NOP, LDI, CPI, JMP, CALL, RET, BREQ};
        bit          zseq [64];
        bit          exp_f;
        logic [1:0]  exp_c;
        logic [7:0]  mpc;
        bit          z;
        int          k;
        int          hs;
        int          k2;
        bit          pend;
        bit          done;
        clear_mem();
        for (int i = 0; i <= 8'h1C; i++) begin
            mem[i] = {ops[$urandom_range(0, 6)], 8'($urandom_range(0, 28)),
                      8'($urandom)};
        end
        for (int i = 0; i < 64; i++) zseq[i] = 1'($urandom);
        mpc = 8'h00;
        z = 1'b0;
        k = 0;
        exp_f = 1'b0;
        exp_c = 2'b00;
        for (int s = 0; s < 60; s++) begin
            logic [23:0] wd;
            if (mpc > 8'h1A) begin
                exp_f = 1'b1;
                exp_c = 2'b11;
                break;
            end
            wd = mem[mpc];
            if (wd[23:16] == JMP) begin
                mpc = wd[15:8];
            end else if (wd[23:16] == CALL) begin
                if (stk.size() == DEPTH) begin
                    exp_f = 1'b1;
                    exp_c = 2'b01;
                    break;
                end
                stk.push_back(mpc + 8'd1);
                mpc = wd[15:8];
            end else if (wd[23:16] == RET) begin
                if (stk.size() == 0) begin
                    exp_f = 1'b1;
                    exp_c = 2'b10;
                    break;
                end
                mpc = stk.pop_back();
            end else if (wd[23:16] == BREQ) begin
                mpc = z ? wd[15:8] : mpc + 8'd1;
            end else begin
                exp_q.push_back({mpc, wd});
                z = zseq[k];
                k++;
                mpc = mpc + 8'd1;
            end
        end
        do_reset();
        hs = 0;
        k2 = 0;
        pend = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < CAP; cyc++) begin
            @(negedge clock);
            if (pend) begin
                zero_flag = zseq[k2];
                k2++;
                pend = 1'b0;
            end
            if (fault || (!exp_f && hs == exp_q.size())) begin
                done = 1'b1;
                break;
            end
            instr_ready = ($urandom_range(0, 3) != 0);
            if (instr_valid && instr_ready) begin
                if (hs < exp_q.size())
                    chk($sformatf("rnd%0d issue%0d", t, hs),
                        {pc, op_code, op1, op2}, exp_q[hs]);
                hs++;
                pend = 1'b1;
            end
        end
        chk($sformatf("rnd%0d finished", t), 32'(done), 32'd1);
        chk($sformatf("rnd%0d issue count", t), 32'(hs), 32'(exp_q.size()));
        chk($sformatf("rnd%0d fault", t), 32'(fault), 32'(exp_f));
        if (exp_f) chk($sformatf("rnd%0d code", t), 32'(fault_code), 32'(exp_c));
        instr_ready = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{{JMP,  8'h05, 8'h00}, 1'b0, 8'h05, 1'b0, 1'b0, 2'b00};
        tbl[1] = '{{CALL, 8'h0D, 8'h00}, 1'b0, 8'h0D, 1'b0, 1'b0, 2'b00};
        tbl[2] = '{{RET,  8'h00, 8'h00}, 1'b0, 8'h00, 1'b0, 1'b1, 2'b10};
        tbl[3] = '{{BREQ, 8'h05, 8'h00}, 1'b1, 8'h05, 1'b0, 1'b0, 2'b00};
        tbl[4] = '{{BREQ, 8'h05, 8'h00}, 1'b0, 8'h01, 1'b0, 1'b0, 2'b00};
        tbl[5] = '{{LDI,  8'h10, 8'h02}, 1'b0, 8'h00, 1'b1, 1'b0, 2'b00};
        tbl[6] = '{{JMP,  8'h1B, 8'h00}, 1'b0, 8'h1B, 1'b0, 1'b0, 2'b00};

        // reset state, then issue and hold
        clear_mem();
        mem[0] = {LDI, 8'h10, 8'h02};
        reset_s2_n = 1'b0;
        @(negedge clock);
        chk("rst pc", 32'(pc), 32'h00);
        chk("rst addr", 32'(rom_address), 32'h00);
        chk("rst valid", 32'(instr_valid), 32'd0);
        chk("rst fields", {8'h00, op_code, op1, op2}, 32'h0);
        chk("rst fault", {30'd0, fault_code}, {31'd0, fault});
        chk("rst fault flag", 32'(fault), 32'd0);
        @(negedge clock);
        reset_s2_n = 1'b1;
        edges(1);
        chk("hold cyc2 valid", 32'(instr_valid), 32'd0);
        edges(1);
        chk("hold cyc3 valid", 32'(instr_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            edges(1);
            chk($sformatf("hold %0d valid", c), 32'(instr_valid), 32'd1);
            chk($sformatf("hold %0d fields", c), {pc, op_code, op1, op2},
                {8'h00, LDI, 8'h10, 8'h02});
        end
        instr_ready = 1'b1;
        edges(1);
        instr_ready = 1'b0;
        chk("hold pc after hs", 32'(pc), 32'h01);
        chk("hold valid after hs", 32'(instr_valid), 32'd0);

        for (int i = 0; i < 7; i++) begin
            clear_mem();
            mem[0] = tbl[i].word;
            do_reset();
            zero_flag = tbl[i].zf;
            edges(2);
            chk($sformatf("tbl%0d pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d addr", i), 32'(rom_address), 32'(tbl[i].pc));
            chk($sformatf("tbl%0d valid", i), 32'(instr_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d fault", i), 32'(fault), 32'(tbl[i].flt));
            chk($sformatf("tbl%0d code", i), 32'(fault_code), 32'(tbl[i].code));
            if (tbl[i].valid)
                chk($sformatf("tbl%0d fields", i), {8'h00, op_code, op1, op2},
                    {8'h00, tbl[i].word});
        end

        // JMP at 8'h03
        clear_mem();
        mem[0] = {JMP, 8'h03, 8'h00};
        mem[3] = {JMP, 8'h05, 8'h00};
        mem[5] = {LDI, 8'h11, 8'h22};
        do_reset();
        edges(2);
        chk("jmp fetch3 addr", 32'(rom_address), 32'h03);
        edges(1);
        chk("jmp decode valid", 32'(instr_valid), 32'd0);
        edges(1);
        chk("jmp target addr", 32'(rom_address), 32'h05);
        chk("jmp target valid", 32'(instr_valid), 32'd0);

        // nested CALL/RET, LIFO order
        clear_mem();
        mem[8'h00] = {CALL, 8'h0D, 8'h00};
        mem[8'h0D] = {JMP,  8'h11, 8'h00};
        mem[8'h11] = {RET,  8'h00, 8'h00};
        mem[8'h01] = {CALL, 8'h14, 8'h00};
        mem[8'h14] = {CALL, 8'h16, 8'h00};
        mem[8'h16] = {RET,  8'h00, 8'h00};
        mem[8'h15] = {RET,  8'h00, 8'h00};
        do_reset();
        edges(2);
        chk("call pc", 32'(pc), 32'h0D);
        edges(4);
        chk("ret pc", 32'(pc), 32'h01);
        edges(4);
        chk("nest inner pc", 32'(pc), 32'h16);
        edges(2);
        chk("nest ret1 pc", 32'(pc), 32'h15);
        edges(2);
        chk("nest ret2 pc", 32'(pc), 32'h02);
        chk("nest fault", 32'(fault), 32'd0);

        // stack overflow
        clear_mem();
        mem[0] = {CALL, 8'h00, 8'h00};
        do_reset();
        edges(2 * DEPTH);
        chk("ovf full no fault", 32'(fault), 32'd0);
        edges(2);
        chk("ovf fault", 32'(fault), 32'd1);
        chk("ovf code", 32'(fault_code), 32'h1);
        edges(4);
        chk("ovf pc frozen", 32'(pc), 32'h00);
        chk("ovf valid", 32'(instr_valid), 32'd0);

        // pc running past ROM_MAX
        clear_mem();
        mem[8'h00] = {JMP, 8'h1A, 8'h00};
        mem[8'h1A] = {LDI, 8'h01, 8'h01};
        do_reset();
        instr_ready = 1'b1;
        edges(4);
        chk("range last valid", 32'(instr_valid), 32'd1);
        edges(1);
        chk("range pc", 32'(pc), 32'h1B);
        chk("range early fault", 32'(fault), 32'd0);
        edges(1);
        chk("range fault", 32'(fault), 32'd1);
        chk("range code", 32'(fault_code), 32'h3);
        for (int c = 0; c < 4; c++) begin
            edges(1);
            chk($sformatf("range halt valid %0d", c), 32'(instr_valid), 32'd0);
        end
        chk("range pc frozen", 32'(pc), 32'h1B);
        instr_ready = 1'b0;

        // asynchronous reset while issuing
        clear_mem();
        mem[0] = {JMP, 8'h04, 8'h00};
        mem[4] = {LDI, 8'h33, 8'h44};
        do_reset();
        edges(4);
        chk("arst pre valid", 32'(instr_valid), 32'd1);
        chk("arst pre pc", 32'(pc), 32'h04);
        #5;
        reset_s2_n = 1'b0;
        #1;
        chk("arst valid", 32'(instr_valid), 32'd0);
        chk("arst pc", 32'(pc), 32'h00);
        chk("arst op", 32'(op_code), 32'h00);
        @(negedge clock);
        reset_s2_n = 1'b1;
        edges(2);
        chk("arst resume pc", 32'(pc), 32'h04);
        edges(2);
        chk("arst resume valid", 32'(instr_valid), 32'd1);

        for (int t = 0; t < 30; t++) rand_trial(t);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch and decode front end of the microcomputer CPU. It is the reader side of the 24-bit program memory `rom`:
- drives the program-memory address from its program counter;
- splits each returned word `{op_code, op1, op2}` back into fields;
- resolves JMP, CALL, RET and BREQ itself, using an internal return stack;
- hands every other instruction to the execution unit over a valid/ready handshake.

## Interface
Parameters:
- STACK_DEPTH, 8: number of return-address entries (1..16).
- ROM_MAX, 8'h1A: highest valid program address.
- PC_RESET, 8'h00: program counter value after reset.

Ports:
- clock  in  1  50 MHz system clock.
- reset_s2_n  in  1  synchronized reset. Asynchronous, active-low.
- rom_address  out  8  program-memory address. Always equal to pc.
- rom_data  in  24  program-memory word. Registered in rom, valid one cycle after the address.
- zero_flag  in  1  Z flag from the execution unit, sampled in DECODE.
- instr_valid  out  1  decoded instruction available to the execution unit.
- instr_ready  in  1  execution unit accepts the instruction.
- op_code  out  8  rom_data[23:16] of the issued instruction.
- op1  out  8  rom_data[15:8].
- op2  out  8  rom_data[7:0].
- pc  out  8  current program counter.
- fault  out  1  sticky halt indication.
- fault_code  out  2  halt cause: 01 = stack overflow, 10 = stack underflow, 11 = address out of range.

## Operation
- Opcode constants CALL, RET, JMP and BREQ come from the def package. All other opcodes are issued to the execution unit.
- Reset (asynchronous, any state), all outputs and registers go immediately to:
  - pc = PC_RESET, state = FETCH;
  - instr_valid = 0, op_code/op1/op2 = 0;
  - fault = 0, fault_code = 00;
  - stack pointer = 0 (stack empty).
- States: FETCH, DECODE, ISSUE, HALT.
- FETCH:
  - if pc > ROM_MAX: fault = 1, fault_code = 11, go to HALT;
  - else go to DECODE (rom captures the word at this edge).
- DECODE: the instruction register is loaded from rom_data, then by opcode:
  - JMP: pc ← op1, go to FETCH.
  - CALL:
    - if the stack is full: fault, code 01, go to HALT;
    - else push pc+1, pc ← op1, go to FETCH.
  - RET:
    - if the stack is empty: fault, code 10, go to HALT;
    - else pop into pc, go to FETCH.
  - BREQ: pc ← op1 if zero_flag = 1, else pc+1; go to FETCH.
  - Other opcodes: go to ISSUE.
- ISSUE:
  - instr_valid = 1 with op_code/op1/op2 from the instruction register;
  - fields stay stable while instr_ready = 0;
  - on instr_valid & instr_ready: pc ← pc+1, instr_valid ← 0, go to FETCH.
- HALT: terminal state until reset. pc frozen, instr_valid = 0.
- Arithmetic width rules:
  - pc+1 is 8-bit, and wraps 8'hFF → 8'h00 (the next FETCH then range-checks it);
  - stack pointer is $clog2(STACK_DEPTH+1) bits wide.
- Stack ordering: the stack is LIFO, and overflow or underflow never corrupts stored entries.

## Timing
- rom_address follows pc combinationally, with no extra register.
- Issued instruction latency: FETCH → DECODE → ISSUE. instr_valid rises on the 3rd cycle after pc is set.
  - With instr_ready held at 1, throughput is one instruction per 3 cycles.
- Flow-control instructions take 2 cycles (FETCH, DECODE).
  - The new pc appears in the cycle after DECODE, with no bubble beyond that.
- Execution unit timing contract:
  - zero_flag must reflect an accepted instruction by the cycle after its handshake;
  - the next DECODE is at least 2 cycles later, so a CPI followed by BREQ resolves correctly.
- Fault indication: fault and fault_code assert in the cycle after the detecting edge.

## Test plan
- Issue and hold:
  - stimulus: reset release, rom word at 8'h00 = {LDI, R16, 8'h02}, instr_ready low for 5 cycles, then high;
  - required: instr_valid = 1 on cycle 3, fields stable for 5 cycles, pc = 8'h01 one cycle after the handshake.
- JMP:
  - stimulus: {JMP, 8'h05, 0} at pc 8'h03;
  - required: rom_address = 8'h05 two cycles after FETCH of 8'h03, instr_valid never asserted.
- CALL/RET and stack limit:
  - stimulus 1: {CALL, 8'h0D} at 8'h00, {RET} at 8'h11;
  - required 1: pc returns to 8'h01;
  - stimulus 2: STACK_DEPTH+1 nested CALLs;
  - required 2: fault = 1, fault_code = 01, HALT, pc frozen.
- BREQ:
  - stimulus: {BREQ, 8'h05} at 8'h03;
  - required: with zero_flag = 1, next pc = 8'h05; with zero_flag = 0, next pc = 8'h04.
- Fault cases:
  - stimulus 1: RET with the stack empty;
  - required 1: fault_code = 10;
  - stimulus 2: pc reaching 8'h1B;
  - required 2: fault_code = 11, no instr_valid.
- Reset during ISSUE:
  - stimulus: assert reset_s2_n = 0 while instr_valid = 1;
  - required: instr_valid = 0 and pc = 8'h00 without waiting for a clock edge, and normal fetch resumes after release.
